// File: rtl/io_map_pkg.sv
// Shared address map and status-byte layout for the processor's MMIO port bridge.
package io_map_pkg;

  localparam logic [7:0] DEFAULT_PORT_ADDR   = 8'hFF;
  localparam logic [7:0] DEFAULT_STATUS_ADDR = 8'hFE;

  // Bit positions inside the status byte
  localparam int ST_RX_NE     = 0;
  localparam int ST_TX_NF     = 1;
  localparam int ST_RX_UF     = 2;
  localparam int ST_TX_OF     = 3;
  localparam int ST_RXCNT_LSB = 4;

  // The status byte only has a 4-bit field for the RX fill level, so larger counts pin at 15
  function automatic logic [3:0] sat_count4(input logic [7:0] n);
    return (n > 8'd15) ? 4'hF : n[3:0];
  endfunction

endpackage

// File: rtl/mmio_port_bridge_if.sv
// Bundles the processor data-memory strobes and the two byte streams of the MMIO port bridge.
interface mmio_port_bridge_if;

  logic [7:0] cpu_addr;
  logic       cpu_mem_read;
  logic       cpu_mem_write;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       cpu_hit;

  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;

  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  // Processor plus stream environment driving the bridge
  modport master (
    output cpu_addr, cpu_mem_read, cpu_mem_write, cpu_wdata, out_ready, in_valid, in_data,
    input  cpu_rdata, cpu_hit, out_valid, out_data, in_ready
  );

  // The bridge itself
  modport slave (
    input  cpu_addr, cpu_mem_read, cpu_mem_write, cpu_wdata, out_ready, in_valid, in_data,
    output cpu_rdata, cpu_hit, out_valid, out_data, in_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with a combinational head; head reads 0 while empty.
// The caller guarantees push is only raised when not full (or together with a pop)
// and pop only when not empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: stale entries are hidden behind the empty flag
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/mmio_port_bridge.sv
// MMIO responder beside data memory: stores to the port address feed the TX FIFO,
// loads from it pop the RX FIFO, and the status address exposes FIFO state plus
// write-1-to-clear sticky error flags.
module mmio_port_bridge
  import io_map_pkg::*;
#(
  parameter int         DEPTH       = 4,
  parameter logic [7:0] PORT_ADDR   = DEFAULT_PORT_ADDR,
  parameter logic [7:0] STATUS_ADDR = DEFAULT_STATUS_ADDR
) (
  input logic                clk,
  input logic                reset,
  mmio_port_bridge_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          hit_port, hit_stat;
  logic          tx_wr, tx_push, tx_pop, tx_full, tx_empty;
  logic [CW-1:0] tx_count;
  logic [7:0]    tx_head;
  logic          rx_rd, rx_push, rx_pop, rx_full, rx_empty;
  logic [CW-1:0] rx_count;
  logic [7:0]    rx_head;
  logic          stat_wr, rx_uf, tx_of, rx_uf_set, tx_of_set;
  logic [7:0]    status;

  assign hit_port = (bus.cpu_addr == PORT_ADDR);
  assign hit_stat = (bus.cpu_addr == STATUS_ADDR);
  assign bus.cpu_hit = (hit_port || hit_stat) && (bus.cpu_mem_read || bus.cpu_mem_write);

  // A write wins over a simultaneous read, so reads only count when no write is present
  assign tx_wr   = bus.cpu_mem_write && hit_port;
  assign rx_rd   = bus.cpu_mem_read && !bus.cpu_mem_write && hit_port;
  assign stat_wr = bus.cpu_mem_write && hit_stat;

  // A full TX FIFO still takes a store when its head leaves in the same cycle
  assign tx_pop    = bus.out_ready && (tx_count != '0);
  assign tx_push   = tx_wr && (!tx_full || tx_pop);
  assign tx_of_set = tx_wr && tx_full && !tx_pop;

  // RX acceptance looks only at occupancy, keeping the stream side free of cpu paths
  assign bus.in_ready = !reset && !rx_full;
  assign rx_push      = bus.in_valid && bus.in_ready;
  assign rx_pop       = rx_rd && !rx_empty;
  assign rx_uf_set    = rx_rd && rx_empty;

  assign bus.out_valid = !tx_empty;
  assign bus.out_data  = tx_head;

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (bus.cpu_wdata),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count),
    .head  (tx_head)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .pop   (rx_pop),
    .wdata (bus.in_data),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count),
    .head  (rx_head)
  );

  // Sticky error flags: a new error in the same cycle beats a write-1-to-clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_uf <= 1'b0;
      tx_of <= 1'b0;
    end else begin
      if (rx_uf_set)                          rx_uf <= 1'b1;
      else if (stat_wr && bus.cpu_wdata[2])   rx_uf <= 1'b0;
      if (tx_of_set)                          tx_of <= 1'b1;
      else if (stat_wr && bus.cpu_wdata[3])   tx_of <= 1'b0;
    end
  end

  // Assemble the status byte from live FIFO state and the sticky flags
  always_comb begin
    status = '0;
    status[ST_RX_NE] = !rx_empty;
    status[ST_TX_NF] = !tx_full;
    status[ST_RX_UF] = rx_uf;
    status[ST_TX_OF] = tx_of;
    status[ST_RXCNT_LSB +: 4] = sat_count4(8'(rx_count));
  end

  // Load data mux; returns 0 on any access that is not a decoded read
  always_comb begin
    bus.cpu_rdata = '0;
    if (bus.cpu_mem_read && !bus.cpu_mem_write) begin
      if (hit_port)      bus.cpu_rdata = rx_head;
      else if (hit_stat) bus.cpu_rdata = status;
    end
  end

endmodule

// File: tb/tb_mmio_port_bridge.sv
// Scoreboard bench for mmio_port_bridge: stimulus queues expected TX bytes and load
// results, a negedge monitor pops and compares them as the DUT presents them.
module tb_mmio_port_bridge;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [7:0] tx_q[$];
  logic [7:0] rd_q[$];
  string      rd_name_q[$];

  mmio_port_bridge_if bus();

  mmio_port_bridge dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One processor cycle on the data-memory bus, strobes dropped afterwards
  task automatic apply_stimulus(input logic rd, input logic wr, input logic [7:0] addr,
                                input logic [7:0] wdata);
    bus.cpu_mem_read  = rd;
    bus.cpu_mem_write = wr;
    bus.cpu_addr      = addr;
    bus.cpu_wdata     = wdata;
    tick();
    bus.cpu_mem_read  = 1'b0;
    bus.cpu_mem_write = 1'b0;
    bus.cpu_addr      = 8'h00;
    bus.cpu_wdata     = 8'h00;
  endtask

  task automatic cpu_store(input logic [7:0] addr, input logic [7:0] data);
    apply_stimulus(1'b0, 1'b1, addr, data);
  endtask

  task automatic cpu_load(input logic [7:0] addr, input logic [7:0] exp, input string name);
    rd_q.push_back(exp);
    rd_name_q.push_back(name);
    apply_stimulus(1'b1, 1'b0, addr, 8'h00);
  endtask

  task automatic rx_send(input logic [7:0] data);
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Monitor: compare whatever the DUT presents against the head of the matching queue
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.out_valid && bus.out_ready) begin
        if (tx_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL tx_unexpected: got %h expected none", bus.out_data);
        end else begin
          check_output("tx_data", bus.out_data, tx_q.pop_front());
        end
      end
      if (bus.cpu_mem_read && bus.cpu_hit) begin
        if (rd_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL rd_unexpected: got %h expected none", bus.cpu_rdata);
        end else begin
          check_output(rd_name_q.pop_front(), bus.cpu_rdata, rd_q.pop_front());
        end
      end
    end
  end

  // Guard against a hung run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.cpu_addr = 8'h00;  bus.cpu_mem_read = 1'b0;  bus.cpu_mem_write = 1'b0;
    bus.cpu_wdata = 8'h00; bus.out_ready = 1'b0;     bus.in_valid = 1'b0;
    bus.in_data = 8'h00;

    // Reset state
    #2;
    check_output("rst_out_valid", 8'(bus.out_valid), 8'h00);
    check_output("rst_out_data", bus.out_data, 8'h00);
    check_output("rst_in_ready", 8'(bus.in_ready), 8'h00);
    #10 reset = 1'b0;
    tick();
    check_output("post_rst_in_ready", 8'(bus.in_ready), 8'h01);
    cpu_load(8'hFE, 8'h02, "rst_status");

    // 1: TX basic
    $display("[TB] test 1 TX basic");
    tx_q.push_back(8'hA5);
    cpu_store(8'hFF, 8'hA5);
    check_output("t1_out_valid", 8'(bus.out_valid), 8'h01);
    check_output("t1_out_data", bus.out_data, 8'hA5);
    bus.out_ready = 1'b1;
    tick();
    check_output("t1_drained", 8'(bus.out_valid), 8'h00);
    bus.out_ready = 1'b0;

    // 2: TX overflow
    $display("[TB] test 2 TX overflow");
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) tx_q.push_back(8'(i));
      cpu_store(8'hFF, 8'(i));
    end
    cpu_load(8'hFE, 8'h08, "t2_status_of");
    bus.out_ready = 1'b1;
    repeat (4) tick();
    bus.out_ready = 1'b0;
    check_output("t2_empty", 8'(bus.out_valid), 8'h00);
    cpu_store(8'hFE, 8'h08);
    cpu_load(8'hFE, 8'h02, "t2_status_clr");

    // 3: RX order and underflow
    $display("[TB] test 3 RX order/underflow");
    rx_send(8'h3C);
    rx_send(8'h3D);
    cpu_load(8'hFF, 8'h3C, "t3_rx0");
    cpu_load(8'hFF, 8'h3D, "t3_rx1");
    cpu_load(8'hFF, 8'h00, "t3_rx_empty");
    cpu_load(8'hFE, 8'h06, "t3_status_uf");
    cpu_store(8'hFE, 8'h04);
    cpu_load(8'hFE, 8'h02, "t3_status_clr");

    // 4: RX full and refill after a pop
    $display("[TB] test 4 RX full");
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = 8'h41 + 8'(i);
      tick();
    end
    bus.in_data = 8'h45;
    check_output("t4_full_in_ready", 8'(bus.in_ready), 8'h00);
    cpu_load(8'hFE, 8'h43, "t4_status_full");
    cpu_load(8'hFF, 8'h41, "t4_pop");
    check_output("t4_in_ready_back", 8'(bus.in_ready), 8'h01);
    tick();
    bus.in_valid = 1'b0;
    check_output("t4_refull", 8'(bus.in_ready), 8'h00);
    for (int i = 0; i < 4; i++) cpu_load(8'hFF, 8'h42 + 8'(i), "t4_drain");
    cpu_load(8'hFE, 8'h02, "t4_status_end");

    // 5: store into a full TX FIFO while its head is leaving
    $display("[TB] test 5 simultaneous TX");
    for (int i = 1; i <= 4; i++) begin
      tx_q.push_back(8'(i * 8'h11));
      cpu_store(8'hFF, 8'(i * 8'h11));
    end
    tx_q.push_back(8'h77);
    bus.out_ready = 1'b1;
    cpu_store(8'hFF, 8'h77);
    repeat (4) tick();
    bus.out_ready = 1'b0;
    check_output("t5_empty", 8'(bus.out_valid), 8'h00);
    cpu_load(8'hFE, 8'h02, "t5_status_no_of");

    // 6: reset mid-stream, then a foreign address
    $display("[TB] test 6 reset mid-stream");
    cpu_store(8'hFF, 8'hAA);
    cpu_store(8'hFF, 8'hBB);
    cpu_store(8'hFF, 8'hCC);
    rx_send(8'h01);
    rx_send(8'h02);
    reset = 1'b1;
    #1;
    check_output("t6_rst_out_valid", 8'(bus.out_valid), 8'h00);
    check_output("t6_rst_in_ready", 8'(bus.in_ready), 8'h00);
    @(negedge clk);
    reset = 1'b0;
    tick();
    cpu_load(8'hFE, 8'h02, "t6_status_after");
    bus.cpu_mem_write = 1'b1; bus.cpu_addr = 8'h10; bus.cpu_wdata = 8'h5A;
    #1;
    check_output("t6_miss_wr_hit", 8'(bus.cpu_hit), 8'h00);
    tick();
    bus.cpu_mem_write = 1'b0; bus.cpu_mem_read = 1'b1;
    #1;
    check_output("t6_miss_rd_hit", 8'(bus.cpu_hit), 8'h00);
    check_output("t6_miss_rdata", bus.cpu_rdata, 8'h00);
    tick();
    bus.cpu_mem_read = 1'b0; bus.cpu_addr = 8'h00; bus.cpu_wdata = 8'h00;
    check_output("t6_miss_out_valid", 8'(bus.out_valid), 8'h00);
    cpu_load(8'hFE, 8'h02, "t6_status_miss");

    // Every queued expectation must have been consumed
    tick();
    check_output("tx_q_left", 8'(tx_q.size()), 8'h00);
    check_output("rd_q_left", 8'(rd_q.size()), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
